bus_arbiter_4: RTL

BUS_ARBITER_4 -- requirements
Module: bus_arbiter_4

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_pick4.sv | 31 +++
 rtl/bus_arbiter_4.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 4-requester round-robin bus arbiter:
// FSM state encodings, requester count, index width and a one-hot helper.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RELEASE = 2'b10
  } arb_state_e;

  // Convert an encoded requester index to its one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] one;
    one = {{(NUM_REQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: scans req starting at 'start' and
// wrapping 3->0, reporting the first asserted requester.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // First asserted request at or after 'start', modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = start + IDX_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_4.sv
// 4-requester round-robin bus arbiter with IDLE/GRANT/RELEASE FSM.
// A RELEASE cycle (gnt = 0) separates consecutive grants for bus turnaround.
// Optional feature: define ARB_TIMEOUT_EN to build the hold counter that
// force-releases a grant after MAX_HOLD consecutive GRANT cycles and pulses
// timeout on the first RELEASE cycle.
module bus_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               busy,
  output logic               timeout
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("bus_arbiter_4: MAX_HOLD must be within 2..255");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               busy_q, busy_d;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   pick_start;
  logic               hold_expire;
  logic               grant_end;

  // Search begins one past the last grant; 2-bit arithmetic gives the 3->0 wrap.
  assign pick_start = gnt_idx_q + 2'd1;

  rr_pick4 u_pick (
    .req   (req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  // Hold counter: zero on GRANT entry and outside GRANT, counts GRANT cycles.
  always_comb begin
    hold_expire = (state_q == ST_GRANT) && (hold_q == HOLD_LAST);
    timeout_d   = hold_expire;
    if ((state_q == ST_GRANT) && (state_d == ST_GRANT)) begin
      hold_d = hold_q + 8'd1;
    end else begin
      hold_d = 8'd0;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  // Only the granted requester's done/req bits can end a grant.
  assign grant_end = done[gnt_idx_q] | ~req[gnt_idx_q] | hold_expire;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE, ST_RELEASE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (grant_end) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values: index latches only on GRANT entry, grant follows it.
  always_comb begin
    gnt_idx_d = gnt_idx_q;
    gnt_d     = '0;
    busy_d    = 1'b0;
    if ((state_q != ST_GRANT) && (state_d == ST_GRANT)) begin
      gnt_idx_d = pick_idx;
    end else begin
      gnt_idx_d = gnt_idx_q;
    end
    if (state_d == ST_GRANT) begin
      gnt_d  = idx_to_onehot(gnt_idx_d);
      busy_d = 1'b1;
    end else begin
      gnt_d  = '0;
      busy_d = 1'b0;
    end
  end

  // Output registers; reset index 3 makes the first search start at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q     <= 4'b0000;
      gnt_idx_q <= 2'd3;
      busy_q    <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign busy    = busy_q;

endmodule
